// File: rtl/crc32_pkg.sv
// Shared constants and state type for the reflected CRC-32 stream block.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } crc_state_e;

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational update of a reflected CRC-32 register by one byte, LSB first.
module crc32_byte_step
  import crc32_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  always_comb begin
    logic [31:0] v_crc;
    v_crc = i_crc;
    for (int b = 0; b < 8; b++) begin
      v_crc = (v_crc >> 1) ^ (CRC32_POLY & {32{v_crc[0] ^ i_byte[b]}});
    end
    o_crc = v_crc;
  end

endmodule

// File: rtl/crc32_stream.sv
// Streaming CRC-32 (Ethernet FCS) generator/checker, DATA_BYTES bytes per beat,
// with frame and error counters.
module crc32_stream
  import crc32_pkg::*;
#(
  parameter int DATA_BYTES = 1,
  parameter int CHECK_MODE = 0,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic                          in_sop,
  input  logic                          in_eop,
  input  logic [8*DATA_BYTES-1:0]       in_data,
  input  logic [$clog2(DATA_BYTES):0]   in_nbytes,
  input  logic                          in_abort,
  output logic                          fcs_valid,
  output logic [31:0]                   fcs_value,
  output logic                          fcs_ok,
  output logic [CNT_W-1:0]              frame_cnt,
  output logic [CNT_W-1:0]              err_cnt
);

  crc_state_e       r_state;
  logic [31:0]      r_crc;
  logic             r_fcs_valid;
  logic [31:0]      r_fcs_value;
  logic             r_fcs_ok;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [31:0] w_seed;
  logic [31:0] w_taps [DATA_BYTES];
  logic [31:0] w_crc_next;
  logic        w_accept;
  logic        w_done;
  logic        w_match;

  // A sop beat always restarts from the initial value, even mid-frame.
  assign w_seed   = in_sop ? CRC32_INIT : r_crc;
  assign w_accept = in_valid && !in_abort && (in_sop || (r_state == ST_IN_FRAME));
  assign w_done   = w_accept && in_eop;

  genvar g;
  for (g = 0; g < DATA_BYTES; g++) begin : g_step
    logic [31:0] w_in;
    logic [31:0] w_out;
    if (g == 0) begin : g_first
      assign w_in = w_seed;
    end else begin : g_next
      assign w_in = g_step[g-1].w_out;
    end
    crc32_byte_step u_step (
      .i_crc  (w_in),
      .i_byte (in_data[8*g +: 8]),
      .o_crc  (w_out)
    );
    assign w_taps[g] = w_out;
  end

  // Tap select: full beat unless eop carries a legal partial count.
  always_comb begin
    int v_n;
    v_n = DATA_BYTES;
    if (in_eop && (int'(in_nbytes) >= 1) && (int'(in_nbytes) <= DATA_BYTES))
      v_n = int'(in_nbytes);
    w_crc_next = w_taps[DATA_BYTES-1];
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (v_n == k + 1) w_crc_next = w_taps[k];
    end
  end

  assign w_match = (w_crc_next == CRC32_RESIDUE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_crc       <= CRC32_INIT;
      r_fcs_valid <= 1'b0;
      r_fcs_value <= 32'h0;
      r_fcs_ok    <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_fcs_valid <= w_done;
      if (in_abort) begin
        r_state <= ST_IDLE;
      end else if (w_accept) begin
        r_crc   <= w_crc_next;
        r_state <= in_eop ? ST_IDLE : ST_IN_FRAME;
      end
      if (w_done) begin
        r_fcs_value <= w_crc_next ^ CRC32_XOROUT;
        r_fcs_ok    <= (CHECK_MODE != 0) && w_match;
        if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + 1'b1;
        if ((CHECK_MODE != 0) && !w_match && (r_err_cnt != '1))
          r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign fcs_valid = r_fcs_valid;
  assign fcs_value = r_fcs_value;
  assign fcs_ok    = r_fcs_ok;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_crc32_stream.sv
// Directed bench for crc32_stream: generator, 4-byte beats, checker, abort,
// restart, saturation and asynchronous reset.
module tb_crc32_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Shared 1-byte bus feeding generator, checker and saturating instances.
  logic       in_valid = 0, in_sop = 0, in_eop = 0, in_abort = 0;
  logic [7:0] in_data = 0;
  logic [0:0] in_nbytes = 1'b1;

  logic        b4_valid = 0, b4_sop = 0, b4_eop = 0, b4_abort = 0;
  logic [31:0] b4_data = 0;
  logic [2:0]  b4_nbytes = 3'd4;

  logic        g1_fv, c1_fv, s1_fv, b4_fv;
  logic [31:0] g1_val, c1_val, s1_val, b4_val;
  logic        g1_ok, c1_ok, s1_ok, b4_ok;
  logic [15:0] g1_fc, g1_ec, c1_fc, c1_ec, b4_fc, b4_ec;
  logic [1:0]  s1_fc, s1_ec;

  crc32_stream #(.DATA_BYTES(1), .CHECK_MODE(0), .CNT_W(16)) u_g1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_nbytes(in_nbytes), .in_abort(in_abort),
    .fcs_valid(g1_fv), .fcs_value(g1_val), .fcs_ok(g1_ok), .frame_cnt(g1_fc), .err_cnt(g1_ec));

  crc32_stream #(.DATA_BYTES(1), .CHECK_MODE(1), .CNT_W(16)) u_c1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_nbytes(in_nbytes), .in_abort(in_abort),
    .fcs_valid(c1_fv), .fcs_value(c1_val), .fcs_ok(c1_ok), .frame_cnt(c1_fc), .err_cnt(c1_ec));

  crc32_stream #(.DATA_BYTES(1), .CHECK_MODE(0), .CNT_W(2)) u_s1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_nbytes(in_nbytes), .in_abort(in_abort),
    .fcs_valid(s1_fv), .fcs_value(s1_val), .fcs_ok(s1_ok), .frame_cnt(s1_fc), .err_cnt(s1_ec));

  crc32_stream #(.DATA_BYTES(4), .CHECK_MODE(0), .CNT_W(16)) u_b4 (
    .clk(clk), .reset(reset), .in_valid(b4_valid), .in_sop(b4_sop), .in_eop(b4_eop),
    .in_data(b4_data), .in_nbytes(b4_nbytes), .in_abort(b4_abort),
    .fcs_valid(b4_fv), .fcs_value(b4_val), .fcs_ok(b4_ok), .frame_cnt(b4_fc), .err_cnt(b4_ec));

  int n_checks = 0;
  int n_fail   = 0;
  int pc_g1 = 0, pc_b4 = 0;

  always @(negedge clk) begin
    if (g1_fv) pc_g1++;
    if (b4_fv) pc_b4++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic sop, input logic eop, input logic abt);
    in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop; in_abort = abt;
    tick();
  endtask

  task automatic idle1();
    in_valid = 0; in_sop = 0; in_eop = 0; in_abort = 0;
  endtask

  task automatic send_str(input string s, input logic sop, input logic eop);
    for (int i = 0; i < s.len(); i++)
      beat(s[i], sop && (i == 0), eop && (i == s.len() - 1), 1'b0);
  endtask

  task automatic beat4(input logic [31:0] d, input logic sop, input logic eop, input logic [2:0] nb);
    b4_valid = 1'b1; b4_data = d; b4_sop = sop; b4_eop = eop; b4_nbytes = nb;
    tick();
  endtask

  task automatic do_reset();
    idle1();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic fcs_bytes(input logic eop_last);
    beat(8'h26, 0, 0, 0);
    beat(8'h39, 0, 0, 0);
    beat(8'hF4, 0, 0, 0);
    beat(8'hCB, 0, eop_last, 0);
  endtask

  int p0;

  initial begin
    // Reset state
    tick();
    check("rst_fv",  g1_fv, 0);
    check("rst_val", g1_val, 0);
    check("rst_ok",  c1_ok, 0);
    check("rst_fc",  g1_fc, 0);
    check("rst_ec",  c1_ec, 0);
    reset = 1'b0;
    tick();

    // Generator, 1 byte/beat, preceded by non-sop bytes that must be ignored
    beat(8'h37, 0, 0, 0);
    beat(8'h38, 0, 0, 0);
    p0 = pc_g1;
    send_str("123456789", 1, 1);
    idle1();
    check("g1_fv",  g1_fv, 1);
    check("g1_val", g1_val, 32'hCBF43926);
    check("g1_fc",  g1_fc, 1);
    check("g1_ok_gen", g1_ok, 0);
    check("c1_bad_ok", c1_ok, 0);
    check("c1_bad_ec", c1_ec, 1);
    tick();
    check("g1_fv_pulse", g1_fv, 0);
    check("g1_val_hold", g1_val, 32'hCBF43926);
    check("g1_npulse", pc_g1 - p0, 1);

    // 4 bytes/beat, partial last beat, then back-to-back frame
    p0 = pc_b4;
    beat4(32'h34333231, 1, 0, 3'd4);
    beat4(32'h38373635, 0, 0, 3'd4);
    beat4(32'hAABBCC39, 0, 1, 3'd1);
    check("b4_fv",  b4_fv, 1);
    check("b4_val", b4_val, 32'hCBF43926);
    beat4(32'h34333231, 1, 0, 3'd4);
    beat4(32'h38373635, 0, 0, 3'd4);
    beat4(32'h00000039, 0, 1, 3'd1);
    b4_valid = 0; b4_sop = 0; b4_eop = 0;
    check("b4_b2b_val", b4_val, 32'hCBF43926);
    check("b4_fc", b4_fc, 2);
    tick();
    check("b4_npulse", pc_b4 - p0, 2);

    // Checker: good frame then frame with bit 0 of first byte flipped
    do_reset();
    send_str("123456789", 1, 0);
    fcs_bytes(1);
    idle1();
    check("c1_fv",  c1_fv, 1);
    check("c1_ok",  c1_ok, 1);
    check("c1_ec0", c1_ec, 0);
    check("c1_val", c1_val, 32'h2144DF1C);
    tick();
    beat(8'h30, 1, 0, 0);
    send_str("23456789", 0, 0);
    fcs_bytes(1);
    idle1();
    check("c1_flip_ok", c1_ok, 0);
    check("c1_flip_ec", c1_ec, 1);
    check("c1_flip_fc", c1_fc, 2);
    tick();
    check("c1_ok_hold", c1_ok, 0);

    // Abort mid-frame (abort beat also carries valid data), then restart
    do_reset();
    p0 = pc_g1;
    send_str("1234", 1, 0);
    beat(8'h35, 0, 1, 1);
    idle1();
    tick();
    check("abort_nofv", pc_g1 - p0, 0);
    send_str("123456789", 1, 1);
    idle1();
    tick();
    check("abort_val", g1_val, 32'hCBF43926);
    check("abort_npulse", pc_g1 - p0, 1);
    check("abort_fc", g1_fc, 1);

    // Mid-frame sop replaces the abort
    do_reset();
    p0 = pc_g1;
    send_str("1234", 1, 0);
    send_str("123456789", 1, 1);
    idle1();
    tick();
    check("resop_val", g1_val, 32'hCBF43926);
    check("resop_npulse", pc_g1 - p0, 1);
    check("resop_fc", g1_fc, 1);

    // Five back-to-back frames: CNT_W=2 counter saturates at 3
    do_reset();
    p0 = pc_g1;
    for (int f = 0; f < 5; f++) send_str("123456789", 1, 1);
    idle1();
    tick();
    check("sat_s1_fc", s1_fc, 3);
    check("sat_g1_fc", g1_fc, 5);
    check("sat_npulse", pc_g1 - p0, 5);
    check("sat_c1_ec", c1_ec, 5);

    // Asynchronous reset mid-frame
    p0 = pc_g1;
    send_str("123", 1, 0);
    in_valid = 1'b1; in_data = 8'h34;
    #3;
    reset = 1'b1;
    #1;
    check("mrst_val", g1_val, 0);
    check("mrst_fc",  g1_fc, 0);
    check("mrst_sfc", s1_fc, 0);
    check("mrst_ec",  c1_ec, 0);
    check("mrst_fv",  g1_fv, 0);
    tick();
    reset = 1'b0;
    idle1();
    tick();
    send_str("56789", 0, 1);
    idle1();
    tick();
    check("mrst_npulse", pc_g1 - p0, 0);
    check("mrst_fc_after", g1_fc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
